solve_task_feeder: RTL

//  Upstream/downstream companion of the interleaved endgame-solver pipeline. Queues incoming

---
 rtl/solve_task_feeder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/solve_task_feeder.sv
// Task feeder for the interleaved endgame solver: queues problems, assigns them to
// round-robin solver contexts, and returns tagged scores on a valid/ready stream.
module solve_task_feeder #(
  parameter int NSLOT      = 7,
  parameter int TAG_W      = 8,
  parameter int TASK_DEPTH = 4,
  parameter int RES_DEPTH  = 8
) (
  input  logic             iCLOCK,
  input  logic             iRESET,
  input  logic             iTaskValid,
  output logic             oTaskReady,
  input  logic [63:0]      iTaskPlayer,
  input  logic [63:0]      iTaskOpponent,
  input  logic [TAG_W-1:0] iTaskId,
  input  logic             iStop,
  output logic             oEnable,
  output logic [63:0]      oPlayer,
  output logic [63:0]      oOpponent,
  input  logic             iSolved,
  input  logic [7:0]       iRes,
  output logic             oResValid,
  input  logic             iResReady,
  output logic [TAG_W-1:0] oResId,
  output logic [7:0]       oResScore
);
  // state | meaning
  // IDLE  | solver disabled, slot pointer parked at 0
  // PRIME | solver loads one context per cycle, NSLOT cycles
  // RUN   | a context is reloaded whenever the solver reports completion
  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

  localparam int SPW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int VCW = $clog2(NSLOT + 1);
  localparam int TPW = (TASK_DEPTH > 1) ? $clog2(TASK_DEPTH) : 1;
  localparam int TCW = $clog2(TASK_DEPTH + 1);
  localparam int RPW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int RCW = $clog2(RES_DEPTH + 1);
  localparam int OCW = $clog2(NSLOT + RES_DEPTH + 1);

  state_t state, state_nxt;
  logic [SPW-1:0] sp;

  logic [63:0]      t_player [TASK_DEPTH];
  logic [63:0]      t_opp    [TASK_DEPTH];
  logic [TAG_W-1:0] t_tag    [TASK_DEPTH];
  logic [TPW-1:0]   t_wr, t_rd;
  logic [TCW-1:0]   t_count;

  logic [TAG_W-1:0] r_tag   [RES_DEPTH];
  logic [7:0]       r_score [RES_DEPTH];
  logic [RPW-1:0]   r_wr, r_rd;
  logic [RCW-1:0]   r_count;

  logic [NSLOT-1:0] slot_valid;
  logic [TAG_W-1:0] slot_tag [NSLOT];
  logic [VCW-1:0]   valid_cnt;
  logic [OCW-1:0]   occupancy;

  logic t_full, t_empty, t_push, t_pop;
  logic r_push, r_pop;
  logic has_credit, present_real, consume;

  always_comb begin
    valid_cnt = '0;
    for (int i = 0; i < NSLOT; i++) valid_cnt = valid_cnt + VCW'(slot_valid[i]);
  end

  // A real task is only issued when its eventual result is sure to fit in the result FIFO.
  assign occupancy    = OCW'(valid_cnt) + OCW'(r_count);
  assign has_credit   = occupancy < OCW'(RES_DEPTH);
  assign t_full       = t_count == TCW'(TASK_DEPTH);
  assign t_empty      = t_count == '0;
  assign oTaskReady   = !t_full;
  assign t_push       = iTaskValid && !t_full;
  assign present_real = !t_empty && has_credit && !iStop;
  assign oPlayer      = present_real ? t_player[t_rd] : '1;
  assign oOpponent    = present_real ? t_opp[t_rd]    : '0;
  assign consume      = (state == S_PRIME) || ((state == S_RUN) && iSolved);
  assign t_pop        = consume && present_real;
  assign r_push       = consume && slot_valid[sp];
  assign oResValid    = r_count != '0;
  assign r_pop        = oResValid && iResReady;
  assign oResId       = r_tag[r_rd];
  assign oResScore    = r_score[r_rd];

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!iStop && (t_push || !t_empty)) state_nxt = S_PRIME;
      S_PRIME: if (sp == SPW'(NSLOT - 1)) state_nxt = S_RUN;
      S_RUN:   if (iStop && valid_cnt == '0 && r_count == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    oEnable = (state != S_IDLE);
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      sp         <= '0;
      slot_valid <= '0;
      slot_tag   <= '{default: '0};
      t_wr       <= '0;
      t_rd       <= '0;
      t_count    <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
    end else begin
      if (!oEnable || state_nxt == S_IDLE || sp == SPW'(NSLOT - 1)) sp <= '0;
      else sp <= sp + 1'b1;

      if (consume) begin
        slot_valid[sp] <= present_real;
        slot_tag[sp]   <= t_tag[t_rd];
      end

      if (t_push) t_wr <= (t_wr == TPW'(TASK_DEPTH - 1)) ? '0 : t_wr + 1'b1;
      if (t_pop)  t_rd <= (t_rd == TPW'(TASK_DEPTH - 1)) ? '0 : t_rd + 1'b1;
      if (t_push && !t_pop)      t_count <= t_count + 1'b1;
      else if (!t_push && t_pop) t_count <= t_count - 1'b1;

      if (r_push) r_wr <= (r_wr == RPW'(RES_DEPTH - 1)) ? '0 : r_wr + 1'b1;
      if (r_pop)  r_rd <= (r_rd == RPW'(RES_DEPTH - 1)) ? '0 : r_rd + 1'b1;
      if (r_push && !r_pop)      r_count <= r_count + 1'b1;
      else if (!r_push && r_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (t_push) begin
      t_player[t_wr] <= iTaskPlayer;
      t_opp[t_wr]    <= iTaskOpponent;
      t_tag[t_wr]    <= iTaskId;
    end
    if (r_push) begin
      r_tag[r_wr]   <= slot_tag[sp];
      r_score[r_wr] <= iRes;
    end
  end
endmodule
